// File: rtl/dice_disp_pkg.sv
// Shared types and 7-segment constants for the dice display output stage.
// Segment codes are active-high, bit0=a .. bit6=g, bit7=dp.
package dice_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } conv_state_t;

    typedef enum logic {
        PH_UNITS,
        PH_TENS
    } phase_t;

    localparam logic [7:0] SEG_OFF = 8'h00;

    localparam logic [7:0] SEG_CODE [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    // Non-decimal codes cannot occur after conversion, but map them dark anyway.
    function automatic logic [7:0] seg_lookup(input logic [3:0] digit);
        logic [7:0] code;
        code = SEG_OFF;
        if (digit <= 4'd9) begin
            code = SEG_CODE[digit];
        end
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using repeated subtraction of ten.
// Inputs of 100 and above are reduced by 100 first, so only two digits remain.
module bin2bcd_seq
    import dice_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       done,
    output logic       busy,
    output logic [3:0] tens,
    output logic [3:0] units
);

    // state  | meaning
    // IDLE   | waiting for start; work registers hold the last result
    // CONV   | one subtraction of ten per cycle while v >= 10
    // COMMIT | result stable; done pulses for one cycle

    conv_state_t state, state_nxt;
    logic [6:0]  v, v_nxt;
    logic [3:0]  tens_q, tens_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            v      <= '0;
            tens_q <= '0;
        end else begin
            state  <= state_nxt;
            v      <= v_nxt;
            tens_q <= tens_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        v_nxt     = v;
        tens_nxt  = tens_q;
        case (state)
            IDLE: begin
                if (start) begin
                    v_nxt     = (bin >= 7'd100) ? (bin - 7'd100) : bin;
                    tens_nxt  = '0;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (v >= 7'd10) begin
                    v_nxt    = v - 7'd10;
                    tens_nxt = tens_q + 4'd1;
                end else begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign done  = (state == COMMIT);
    assign busy  = (state != IDLE);
    assign tens  = tens_q;
    assign units = v[3:0];

endmodule

// File: rtl/dice_display_mux.sv
// Two-digit multiplexed 7-segment driver for the dice roll result.
// Internal segment/common signals are active-high and registered; polarity is applied at the pins.
module dice_display_mux
    import dice_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 1024,
    parameter int GUARD       = 16,
    parameter int CNT_W       = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] value,
    input  logic       value_valid,
    input  logic       blank,
    input  logic       seg_pol,
    input  logic       com_pol,
    output logic [7:0] seg_out,
    output logic       com1,
    output logic       com10,
    output logic       busy
);

    logic             conv_done;
    logic [3:0]       conv_tens;
    logic [3:0]       conv_units;
    logic             conv_start;

    logic [CNT_W-1:0] refresh_cnt;
    phase_t           phase;
    logic [3:0]       shown_units;
    logic [3:0]       shown_tens;
    logic             shown_valid;

    logic [7:0]       seg_hi, seg_nxt;
    logic             com1_hi, com1_nxt;
    logic             com10_hi, com10_nxt;
    logic             in_guard;
    logic [7:0]       digit_code;

    assign conv_start = value_valid && !busy;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (value),
        .done  (conv_done),
        .busy  (busy),
        .tens  (conv_tens),
        .units (conv_units)
    );

    // Both digits swap on the same edge so the display never shows a half-updated value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shown_units <= '0;
            shown_tens  <= '0;
            shown_valid <= 1'b0;
        end else if (conv_done) begin
            shown_units <= conv_units;
            shown_tens  <= conv_tens;
            shown_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            phase       <= PH_UNITS;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            phase       <= (phase == PH_UNITS) ? PH_TENS : PH_UNITS;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_comb begin
        in_guard   = (refresh_cnt < CNT_W'(GUARD));
        digit_code = SEG_OFF;
        if (phase == PH_UNITS) begin
            digit_code = seg_lookup(shown_units);
        end else if (shown_tens != 4'd0) begin
            digit_code = seg_lookup(shown_tens);
        end

        seg_nxt   = digit_code;
        com1_nxt  = !in_guard && (phase == PH_UNITS);
        com10_nxt = !in_guard && (phase == PH_TENS);
        if (in_guard || blank || !shown_valid) begin
            seg_nxt = SEG_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_hi   <= SEG_OFF;
            com1_hi  <= 1'b0;
            com10_hi <= 1'b0;
        end else begin
            seg_hi   <= seg_nxt;
            com1_hi  <= com1_nxt;
            com10_hi <= com10_nxt;
        end
    end

    assign seg_out = seg_hi ^ {8{~seg_pol}};
    assign com1    = com1_hi ^ ~com_pol;
    assign com10   = com10_hi ^ ~com_pol;

endmodule

// File: tb/tb_dice_display_mux.sv
// Scoreboard bench for dice_display_mux with a short refresh period.
// Expected digit codes are queued at load time and checked over one full refresh cycle.
module tb_dice_display_mux;

    localparam int DIV = 8;
    localparam int GRD = 1;

    typedef struct packed {
        logic [7:0] u;
        logic [7:0] t;
    } disp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] value = '0;
    logic       value_valid = 1'b0;
    logic       blank = 1'b0;
    logic       seg_pol = 1'b1;
    logic       com_pol = 1'b0;
    logic [7:0] seg_out;
    logic       com1;
    logic       com10;
    logic       busy;

    int    checks = 0;
    int    errors = 0;
    disp_t sb_q[$];

    dice_display_mux #(
        .REFRESH_DIV (DIV),
        .GUARD       (GRD),
        .CNT_W       (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .value_valid (value_valid),
        .blank       (blank),
        .seg_pol     (seg_pol),
        .com_pol     (com_pol),
        .seg_out     (seg_out),
        .com1        (com1),
        .com10       (com10),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'h3F;
            1: return 8'h06;
            2: return 8'h5B;
            3: return 8'h4F;
            4: return 8'h66;
            5: return 8'h6D;
            6: return 8'h7D;
            7: return 8'h07;
            8: return 8'h7F;
            9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    function automatic disp_t model(input int val);
        int    v;
        disp_t d;
        v   = (val >= 100) ? val - 100 : val;
        d.u = seg_of(v % 10);
        d.t = (v / 10 == 0) ? 8'h00 : seg_of(v / 10);
        return d;
    endfunction

    // Observe one full refresh period (both phases) against the oldest queued expectation.
    task automatic check_display(input string tag);
        disp_t      e;
        logic [7:0] inv;
        int         n1, n10;
        logic       a1, a10;
        check_val({tag, "_sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() == 0) return;
        e   = sb_q.pop_front();
        inv = {8{~seg_pol}};
        n1  = 0;
        n10 = 0;
        @(negedge clk);
        for (int i = 0; i < 2 * DIV; i++) begin
            a1  = (com1 === com_pol);
            a10 = (com10 === com_pol);
            check_val({tag, "_mutex"}, {31'd0, a1 & a10}, 0);
            if (a1) begin
                n1++;
                check_val({tag, "_seg_units"}, seg_out, e.u ^ inv);
            end else if (a10) begin
                n10++;
                check_val({tag, "_seg_tens"}, seg_out, e.t ^ inv);
            end else begin
                check_val({tag, "_seg_guard"}, seg_out, inv);
            end
            @(negedge clk);
        end
        check_val({tag, "_units_cycles"}, n1, DIV - GRD);
        check_val({tag, "_tens_cycles"}, n10, DIV - GRD);
    endtask

    // Strobe val, optionally re-strobe inj_val while busy, and measure the busy length.
    task automatic load_value(input string tag, input int val, input int inject_at,
                              input int inj_val, input int exp_busy);
        int n;
        @(negedge clk);
        value       = 7'(val);
        value_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            value_valid = (n == inject_at);
            if (n == inject_at) value = 7'(inj_val);
            @(negedge clk);
            n++;
        end
        value_valid = 1'b0;
        check_val({tag, "_busy_cycles"}, n, exp_busy);
        sb_q.push_back(model(val));
        check_display(tag);
    endtask

    initial begin
        // Reset state with normal polarity
        #1;
        check_val("rst_seg", seg_out, 8'h00);
        check_val("rst_com1", com1, 1);
        check_val("rst_com10", com10, 1);
        check_val("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back('{u: 8'h00, t: 8'h00});
        check_display("empty");

        load_value("v57", 57, -1, 0, 7);
        load_value("v7", 7, -1, 0, 2);
        load_value("v100", 100, -1, 0, 2);
        load_value("v127", 127, -1, 0, 4);

        // Polarity inversion applies immediately to existing digits
        load_value("v42", 42, -1, 0, 6);
        seg_pol = 1'b0;
        com_pol = 1'b1;
        sb_q.push_back(model(42));
        check_display("inv42");
        seg_pol = 1'b1;
        com_pol = 1'b0;

        // Strobe while busy is dropped
        load_value("v99", 99, 2, 3, 11);
        load_value("v3", 3, -1, 0, 2);

        // Blanking
        load_value("v88", 88, -1, 0, 10);
        blank = 1'b1;
        sb_q.push_back('{u: 8'h00, t: 8'h00});
        check_display("blank");
        blank = 1'b0;
        sb_q.push_back(model(88));
        check_display("unblank");

        // Reset in the middle of a conversion
        @(negedge clk);
        value       = 7'd95;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        @(negedge clk);
        check_val("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_seg", seg_out, 8'h00);
        check_val("mid_rst_com1", com1, 1);
        check_val("mid_rst_com10", com10, 1);
        check_val("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back('{u: 8'h00, t: 8'h00});
        check_display("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
